fetch_realign: RTL and testbench
================================

Name: fetch_realign

Overview:
- Sits between the icache response and the instruction pre-decode/expand stage.
- Turns a stream of word-aligned 32-bit fetch words into a stream of whole instructions, each with its own PC.
- Handles RVC halfwords and 32-bit instructions that straddle two fetch words.
- Holds one leftover halfword and one registered output slot; honours valid/ready on both sides and drops stale words after a redirect.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; halfword-aligned.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
fetch_addr_i  in  32  address of fetch word; bits[1:0]=0
fetch_data_i  in  32  fetch word; bits[15:0] = halfword at fetch_addr_i
fetch_valid_i  in  1  fetch word valid
fetch_ready_o  out  1  word accepted when fetch_valid_i && fetch_ready_o
flush_i  in  1  redirect; highest priority
redirect_pc_i  in  32  new PC on flush_i; bit0=0
inst_o  out  32  instruction; for RVC, [15:0]=halfword and [31:16]=0
inst_pc_o  out  32  PC of inst_o
inst_is_rvc_o  out  1  inst_o is 16-bit
inst_valid_o  out  1  output slot full
inst_ready_i  in  1  downstream consumes slot when inst_valid_o && inst_ready_i

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- On rst:
  - pc <= RESET_PC, hb_valid <= 0, hb <= 0.
  - inst_valid_o <= 0; inst_o, inst_pc_o, inst_is_rvc_o <= 0.
  - fetch_ready_o reads 0 while rst=1.
- State:
  - pc = start of the next instruction to emit.
  - hb = 16-bit holding buffer; hb_valid=1 means hb is the halfword at pc. hb is always an upper half, so hb_valid=1 implies pc[1]=1.
- RVC test on a halfword h: rvc(h) = (h[1:0] != 2'b11).
- slot_free = !inst_valid_o || inst_ready_i.
- Expected word address: exp = hb_valid ? pc+2 : {pc[31:2],2'b00}.
- Fetch words whose fetch_addr_i != exp are stale:
  - fetch_ready_o=1 for them; they are accepted and discarded with no state change.
- Processing cases, one per cycle when not flushing:
  - A) hb_valid && rvc(hb):
    - No word needed; fetch_ready_o=0.
    - If slot_free: emit {16'b0,hb} at pc, rvc=1; pc += 2; hb_valid <= 0.
  - B) hb_valid && !rvc(hb):
    - fetch_ready_o = slot_free.
    - On an accepted word w: emit {w[15:0],hb} at pc, rvc=0; pc += 4; hb <= w[31:16]; hb_valid stays 1.
  - C) !hb_valid && pc[1]==0:
    - fetch_ready_o = slot_free.
    - On w with rvc(w[15:0]): emit {16'b0,w[15:0]}, rvc=1; pc += 2; hb <= w[31:16]; hb_valid <= 1.
    - On w otherwise: emit w, rvc=0; pc += 4; hb_valid stays 0.
  - D) !hb_valid && pc[1]==1 (after a redirect):
    - fetch_ready_o=1 (no emission).
    - On w: hb <= w[31:16]; hb_valid <= 1; w[15:0] dropped.
- Output slot:
  - "Emit" loads inst_o/inst_pc_o/inst_is_rvc_o and sets inst_valid_o <= 1 at the clock edge.
  - If the slot is consumed and nothing is emitted, inst_valid_o <= 0.
  - Slot contents are stable while inst_valid_o && !inst_ready_i.
  - Latency: fetch word accepted at edge N -> instruction visible after edge N. Case A needs no fetch word.
  - Throughput: 1 instruction/cycle.
- Flush:
  - flush_i=1 overrides everything: pc <= redirect_pc_i; hb_valid <= 0; inst_valid_o <= 0.
  - fetch_ready_o=1 and any word presented that cycle is dropped.
  - The next cycle follows case C or D per redirect_pc_i[1].
- Simultaneous: flush_i beats a downstream consume and beats fetch acceptance. rst beats flush_i.
- PC arithmetic is 32-bit modulo; wrap-around at 0xFFFF_FFFE is not special-cased.
- Downstream stall never loses a held halfword and never accepts a word the block cannot place.

Test Plan:
- Reset: rst=1 for 2 cycles -> inst_valid_o=0, fetch_ready_o=0. After release, fetch @0x8000_0000 data 0x0000_0513 -> inst_o=0x0000_0513, pc_o=0x8000_0000, rvc=0.
- Two RVC in one word: @0x8000_0000 data 0x4505_4501 -> 0x0000_4501 @..00, then 0x0000_4505 @..02 (fetch_ready_o=0 that cycle); next word expected at 0x8000_0004.
- Straddle: words 0x0513_4501 @..00 and 0x0000_0000 @..04 -> 0x0000_4501 @..00, then 0x0000_0513 @..02 rvc=0, hb=0x0000, next pc 0x8000_0006.
- Redirect to odd halfword: flush_i with redirect_pc_i=0x8000_0102, then word @0x8000_0100 data 0x4505_FFFF -> low half dropped, emits 0x0000_4505 @0x8000_0102.
- Stale and backpressure: after flush to 0x8000_0200, word @0x8000_0010 is dropped with no output. Hold inst_ready_i=0 for 3 cycles -> inst_o stable, fetch_ready_o=0 in case B/C.
- Flush mid-straddle: hb_valid=1, flush_i with redirect_pc_i=0x8000_0400 while inst_valid_o=1 -> next cycle inst_valid_o=0, hb_valid=0, exp=0x8000_0400.

Source files
------------

// File: rtl/fetch_realign.sv
// rtl/fetch_realign.sv - realigns word-aligned fetch data into whole RVC/32-bit instructions with PCs
// Keeps one leftover upper halfword plus one registered output slot.
module fetch_realign #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_addr_i,
  input  logic [31:0] fetch_data_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_is_rvc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  logic [31:0] pc;
  logic [15:0] hb;
  logic        hb_valid;

  logic        slot_free;
  logic [31:0] exp_addr;
  logic        stale;
  logic        hb_rvc;
  logic        lo_rvc;
  logic        take;
  logic [31:0] pc_n;
  logic [15:0] hb_n;
  logic        hb_valid_n;
  logic        emit;
  logic [31:0] emit_inst;
  logic        emit_rvc;

  always_comb begin
    slot_free = !inst_valid_o || inst_ready_i;
    exp_addr  = hb_valid ? pc + 32'd2 : {pc[31:2], 2'b00};
    stale     = (fetch_addr_i != exp_addr);
    hb_rvc    = (hb[1:0] != 2'b11);
    lo_rvc    = (fetch_data_i[1:0] != 2'b11);

    // Stale words are always swallowed so a redirected icache cannot wedge us.
    if (rst)
      fetch_ready_o = 1'b0;
    else if (flush_i || stale)
      fetch_ready_o = 1'b1;
    else if (hb_valid)
      fetch_ready_o = hb_rvc ? 1'b0 : slot_free;
    else if (pc[1])
      fetch_ready_o = 1'b1;
    else
      fetch_ready_o = slot_free;

    take = fetch_valid_i && fetch_ready_o && !stale;
  end

  always_comb begin
    pc_n       = pc;
    hb_n       = hb;
    hb_valid_n = hb_valid;
    emit       = 1'b0;
    emit_inst  = 32'h0;
    emit_rvc   = 1'b0;

    if (hb_valid && hb_rvc) begin
      if (slot_free) begin
        emit       = 1'b1;
        emit_inst  = {16'h0, hb};
        emit_rvc   = 1'b1;
        pc_n       = pc + 32'd2;
        hb_valid_n = 1'b0;
      end
    end else if (hb_valid) begin
      if (take) begin
        emit      = 1'b1;
        emit_inst = {fetch_data_i[15:0], hb};
        pc_n      = pc + 32'd4;
        hb_n      = fetch_data_i[31:16];
      end
    end else if (!pc[1]) begin
      if (take) begin
        emit = 1'b1;
        if (lo_rvc) begin
          emit_inst  = {16'h0, fetch_data_i[15:0]};
          emit_rvc   = 1'b1;
          pc_n       = pc + 32'd2;
          hb_n       = fetch_data_i[31:16];
          hb_valid_n = 1'b1;
        end else begin
          emit_inst = fetch_data_i;
          pc_n      = pc + 32'd4;
        end
      end
    end else if (take) begin
      // Redirect landed on an upper half: the lower half precedes the target.
      hb_n       = fetch_data_i[31:16];
      hb_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      hb            <= 16'h0;
      hb_valid      <= 1'b0;
      inst_o        <= 32'h0;
      inst_pc_o     <= 32'h0;
      inst_is_rvc_o <= 1'b0;
      inst_valid_o  <= 1'b0;
    end else if (flush_i) begin
      pc           <= redirect_pc_i;
      hb_valid     <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      pc       <= pc_n;
      hb       <= hb_n;
      hb_valid <= hb_valid_n;
      if (emit) begin
        inst_o        <= emit_inst;
        inst_pc_o     <= pc;
        inst_is_rvc_o <= emit_rvc;
        inst_valid_o  <= 1'b1;
      end else if (inst_ready_i) begin
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_realign.sv
// tb/tb_fetch_realign.sv - directed and randomized checks of fetch_realign against a program-walk model
// Random phase: the expected stream is the program memory walked from each redirect target.
module tb_fetch_realign;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_rvc;
  logic        inst_valid;
  logic        inst_ready;

  fetch_realign #(.RESET_PC(32'h8000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_addr_i  (fetch_addr),
    .fetch_data_i  (fetch_data),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .flush_i       (flush),
    .redirect_pc_i (redirect_pc),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_is_rvc_o (inst_is_rvc),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic rdy;
  logic [31:0] salt;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rvc;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one cycle: inputs set away from the edge, ready sampled before it, outputs after it.
  task automatic cyc(input logic r, input logic fl, input logic [31:0] rp, input logic fv,
                     input logic [31:0] fa, input logic [31:0] fd, input logic ir);
    rst = r; flush = fl; redirect_pc = rp;
    fetch_valid = fv; fetch_addr = fa; fetch_data = fd; inst_ready = ir;
    #1 rdy = fetch_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] i, input logic [31:0] p, input logic r);
    check({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    check({tag, "_inst"}, inst, i);
    check({tag, "_pc"}, inst_pc, p);
    check({tag, "_rvc"}, {31'h0, inst_is_rvc}, {31'h0, r});
  endtask

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] x;
    x = (a ^ salt) * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    if (x[20]) x[1:0] = 2'b11;
    return x[15:0];
  endfunction

  // Walk the program from p the way a core would execute it sequentially.
  task automatic rebuild(input logic [31:0] start);
    logic [31:0] p;
    logic [15:0] h;
    exp_t e;
    expq.delete();
    p = start;
    for (int k = 0; k < 200; k++) begin
      h = hw(p);
      e.pc = p;
      if (h[1:0] != 2'b11) begin
        e.inst = {16'h0, h}; e.rvc = 1'b1; p = p + 32'd2;
      end else begin
        e.inst = {hw(p + 32'd2), h}; e.rvc = 1'b0; p = p + 32'd4;
      end
      expq.push_back(e);
    end
  endtask

  localparam logic [31:0] B = 32'h8000_0000;

  initial begin
    logic [31:0] fa, rp, addr, data;
    logic fl, ir, fv, st, prev_fl;
    exp_t e;

    rst = 1'b1; flush = 1'b0; redirect_pc = 32'h0; fetch_valid = 1'b0;
    fetch_addr = 32'h0; fetch_data = 32'h0; inst_ready = 1'b0;
    salt = $urandom;

    cyc(1, 0, 0, 1, B, 32'h0000_0513, 1);
    cyc(1, 0, 0, 1, B, 32'h0000_0513, 1);
    check("rst_ready", {31'h0, rdy}, 32'h0);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);

    cyc(0, 0, 0, 1, B, 32'h0000_0513, 1);
    check("first_ready", {31'h0, rdy}, 32'h1);
    chk_out("first", 32'h0000_0513, B, 0);

    cyc(0, 1, B, 0, 0, 0, 1);
    check("flush_valid", {31'h0, inst_valid}, 32'h0);
    cyc(0, 0, 0, 1, B, 32'h4505_4501, 1);
    chk_out("rvc2_a", 32'h0000_4501, B, 1);
    cyc(0, 0, 0, 1, B + 4, 32'h0, 1);
    check("rvc2_ready", {31'h0, rdy}, 32'h0);
    chk_out("rvc2_b", 32'h0000_4505, B + 2, 1);

    cyc(0, 1, B, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, B, 32'h0513_4501, 1);
    chk_out("str_a", 32'h0000_4501, B, 1);
    cyc(0, 0, 0, 1, B + 4, 32'h0, 1);
    chk_out("str_b", 32'h0000_0513, B + 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk_out("str_c", 32'h0, B + 6, 1);

    cyc(0, 1, B + 32'h102, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, B + 32'h100, 32'h4505_FFFF, 1);
    check("odd_noemit", {31'h0, inst_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk_out("odd", 32'h0000_4505, B + 32'h102, 1);

    cyc(0, 1, B + 32'h200, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, B + 32'h10, 32'h1234_5678, 1);
    check("stale_ready", {31'h0, rdy}, 32'h1);
    check("stale_noemit", {31'h0, inst_valid}, 32'h0);
    cyc(0, 0, 0, 1, B + 32'h200, 32'h0000_0513, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, B + 32'h204, 32'h0000_0593, 0);
      check("bp_ready", {31'h0, rdy}, 32'h0);
      chk_out("bp_hold", 32'h0000_0513, B + 32'h200, 0);
    end
    cyc(0, 0, 0, 1, B + 32'h204, 32'h0000_0593, 1);
    chk_out("bp_release", 32'h0000_0593, B + 32'h204, 0);

    cyc(0, 1, B, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, B, 32'h0513_4501, 1);
    cyc(0, 1, B + 32'h400, 1, B + 4, 32'h0, 0);
    check("mid_flush_valid", {31'h0, inst_valid}, 32'h0);
    cyc(0, 0, 0, 1, B + 4, 32'h0000_0513, 1);
    check("mid_old_stale", {31'h0, inst_valid}, 32'h0);
    cyc(0, 0, 0, 1, B + 32'h400, 32'h4505_4501, 1);
    chk_out("mid_new", 32'h0000_4501, B + 32'h400, 1);

    fa = 32'h0;
    prev_fl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      fl = (i == 0) || ($urandom_range(0, 99) < 3);
      rp = B + ($urandom_range(0, 4095) << 1);
      ir = ($urandom_range(0, 9) < 7);
      fv = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 9) == 0);
      addr = st ? (fa ^ 32'h0000_0100) : fa;
      data = st ? $urandom : {hw(fa + 32'd2), hw(fa)};
      rst = 1'b0; flush = fl; redirect_pc = rp;
      fetch_valid = fv; fetch_addr = addr; fetch_data = data; inst_ready = ir;
      #1 rdy = fetch_ready;
      if (prev_fl) check("rnd_flush_clr", {31'h0, inst_valid}, 32'h0);
      if (!fl && inst_valid && ir) begin
        if (expq.size() == 0) begin
          check("rnd_extra", 32'h1, 32'h0);
        end else begin
          e = expq.pop_front();
          check("rnd_inst", inst, e.inst);
          check("rnd_pc", inst_pc, e.pc);
          check("rnd_rvc", {31'h0, inst_is_rvc}, {31'h0, e.rvc});
        end
      end
      if (!fl && fv && rdy && !st) fa = fa + 32'd4;
      if (fl) begin
        rebuild(rp);
        fa = {rp[31:2], 2'b00};
      end
      prev_fl = fl;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
